// File: rtl/core_isa_pkg.sv
// Shared ISA constants and sequencer state encoding for the matrix-multiplication core cluster.
// Opcode values are fixed by the instruction-memory image format.
package core_isa_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned OP_W_DEF    = 8;
    localparam int unsigned N_CORES_DEF = 4;

    localparam int unsigned OP_EN0    = 3;
    localparam int unsigned OP_EN1    = 4;
    localparam int unsigned OP_EN2    = 5;
    localparam int unsigned OP_EN3    = 6;
    localparam int unsigned OP_ENALL  = 7;
    localparam int unsigned OP_RSTALL = 8;
    localparam int unsigned OP_END    = 38;
    localparam int unsigned OP_JUMNZ  = 40;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StOpFetch,
        StOpWait,
        StHalt
    } seq_state_e;

endpackage

// File: rtl/core_mask_decoder.sv
// Combinational core-enable decoder: next mask for an opcode, and whether the opcode
// is consumed locally (mask ops) rather than issued to the cores.
module core_mask_decoder
    import core_isa_pkg::*;
#(
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned N_CORES = N_CORES_DEF
) (
    input  logic [OP_W-1:0]    i_op,
    input  logic [N_CORES-1:0] i_mask,
    output logic [N_CORES-1:0] o_mask,
    output logic               o_local
);

    always_comb begin
        o_mask  = i_mask;
        o_local = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (i_op == OP_W'(OP_EN0 + i)) begin
                o_mask  = N_CORES'(1) << i;
                o_local = 1'b1;
            end
        end
        if (i_op == OP_W'(OP_ENALL)) begin
            o_mask  = '1;
            o_local = 1'b1;
        end
        // RSTALL re-enables every core but is still issued so they all see it.
        if (i_op == OP_W'(OP_RSTALL)) begin
            o_mask = '1;
        end
    end

endmodule

// File: rtl/core_fetch_sequencer.sv
// Instruction fetch/decode sequencer: owns the PC, handles mask/END/JUMNZ locally and
// issues all other opcodes to the cores over a valid/ready handshake.
module core_fetch_sequencer
    import core_isa_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned N_CORES = N_CORES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [OP_W-1:0]    imem_instr,
    output logic [OP_W-1:0]    op_out,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [N_CORES-1:0] core_en,
    input  logic [N_CORES-1:0] z_in,
    output logic               halted,
    output logic               busy
);

    seq_state_e         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [OP_W-1:0]    r_op_out;
    logic               r_op_valid;
    logic [N_CORES-1:0] r_core_en;
    logic               r_halted;
    logic               r_flag;

    seq_state_e         w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [OP_W-1:0]    w_op_nxt;
    logic               w_valid_nxt;
    logic [N_CORES-1:0] w_en_nxt;
    logic               w_halted_nxt;
    logic               w_flag_nxt;

    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_pc_inc2;
    logic               w_zero;
    logic [N_CORES-1:0] w_dec_mask;
    logic               w_dec_local;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_pc_inc2 = r_pc + ADDR_W'(2);
    // Disabled cores count as zero, so an empty mask reads as zero.
    assign w_zero    = &(z_in | ~r_core_en);

    core_mask_decoder #(
        .OP_W    (OP_W),
        .N_CORES (N_CORES)
    ) u_mask_dec (
        .i_op    (imem_instr),
        .i_mask  (r_core_en),
        .o_mask  (w_dec_mask),
        .o_local (w_dec_local)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_imem_addr <= '0;
            r_op_out    <= '0;
            r_op_valid  <= 1'b0;
            r_core_en   <= '1;
            r_halted    <= 1'b0;
            r_flag      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_imem_addr <= w_addr_nxt;
            r_op_out    <= w_op_nxt;
            r_op_valid  <= w_valid_nxt;
            r_core_en   <= w_en_nxt;
            r_halted    <= w_halted_nxt;
            r_flag      <= w_flag_nxt;
        end
    end

    // The address register follows the PC on every PC update, so the memory sees the
    // new address during FETCH and the byte is ready in DECODE.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_addr_nxt   = r_imem_addr;
        w_op_nxt     = r_op_out;
        w_valid_nxt  = r_op_valid;
        w_en_nxt     = r_core_en;
        w_halted_nxt = r_halted;
        w_flag_nxt   = r_flag;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StFetch;
                    w_pc_nxt    = '0;
                    w_addr_nxt  = '0;
                end
            end
            StFetch: begin
                w_addr_nxt  = r_pc;
                w_state_nxt = StDecode;
            end
            StDecode: begin
                if (w_dec_local) begin
                    w_en_nxt    = w_dec_mask;
                    w_pc_nxt    = w_pc_inc;
                    w_addr_nxt  = w_pc_inc;
                    w_state_nxt = StFetch;
                end else if (imem_instr == OP_W'(OP_END)) begin
                    if (w_zero) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = StHalt;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_addr_nxt  = w_pc_inc;
                        w_state_nxt = StFetch;
                    end
                end else if (imem_instr == OP_W'(OP_JUMNZ)) begin
                    w_flag_nxt  = w_zero;
                    w_addr_nxt  = w_pc_inc;
                    w_state_nxt = StOpFetch;
                end else begin
                    w_en_nxt    = w_dec_mask;
                    w_op_nxt    = imem_instr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                if (op_ready) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_pc_inc;
                    w_addr_nxt  = w_pc_inc;
                    w_state_nxt = StFetch;
                end
            end
            StOpFetch: begin
                w_state_nxt = StOpWait;
            end
            StOpWait: begin
                if (!r_flag) begin
                    w_pc_nxt   = ADDR_W'(imem_instr);
                    w_addr_nxt = ADDR_W'(imem_instr);
                end else begin
                    w_pc_nxt   = w_pc_inc2;
                    w_addr_nxt = w_pc_inc2;
                end
                w_state_nxt = StFetch;
            end
            StHalt: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign imem_addr = r_imem_addr;
    assign op_out    = r_op_out;
    assign op_valid  = r_op_valid;
    assign core_en   = r_core_en;
    assign halted    = r_halted;
    assign busy      = (r_state != StIdle) && (r_state != StHalt);

endmodule
